// File: rtl/fm_pkg.sv
// Shared types and constants for the FM channel scanner.
package fm_pkg;

  localparam int unsigned PHI_W          = 32;
  localparam int unsigned N_CH_DEF       = 8;
  localparam int unsigned SETTLE_CYC_DEF = 64;
  localparam int unsigned MEAS_LOG2_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEAS,
    ST_CMP,
    ST_LOCK
  } scan_state_t;

endpackage

// File: rtl/iq_mag_acc.sv
// |I|+|Q| magnitude estimate accumulated over a measurement window.
module iq_mag_acc (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic signed [15:0] i_in,
  input  logic signed [15:0] q_in,
  output logic [31:0]        acc
);

  logic [16:0] i_ext, q_ext, abs_i, abs_q;
  logic [17:0] sum;

  // 17-bit result so that |-32768| = 32768 is representable
  always_comb begin
    i_ext = {i_in[15], i_in};
    q_ext = {q_in[15], q_in};
    abs_i = i_in[15] ? (~i_ext + 17'd1) : i_ext;
    abs_q = q_in[15] ? (~q_ext + 17'd1) : q_ext;
    sum   = {1'b0, abs_i} + {1'b0, abs_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + 32'(sum);
    end
  end

endmodule

// File: rtl/fm_scan_ctrl.sv
// Steps the NCO across N_CH channels, measures each, then locks to the strongest.
module fm_scan_ctrl
  import fm_pkg::*;
#(
  parameter int unsigned N_CH       = N_CH_DEF,
  parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int unsigned MEAS_LOG2  = MEAS_LOG2_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [PHI_W-1:0]        base_phi,
  input  logic [PHI_W-1:0]        step_phi,
  input  logic signed [15:0]      I_in,
  input  logic signed [15:0]      Q_in,
  output logic [PHI_W-1:0]        phi_inc,
  output logic                    busy,
  output logic                    done,
  output logic                    locked,
  output logic [$clog2(N_CH)-1:0] best_ch,
  output logic [31:0]             best_mag
);

  localparam int unsigned CH_W        = $clog2(N_CH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);
  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYC - 1);
  localparam logic [31:0] MEAS_LAST   = 32'((1 << MEAS_LOG2) - 1);

  scan_state_t      state;
  logic [CH_W-1:0]  ch;
  logic [31:0]      cnt;
  logic [PHI_W-1:0] base_q, step_q, best_phi;
  logic [31:0]      acc;

  iq_mag_acc u_mag (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == ST_SETTLE),
    .en   (state == ST_MEAS),
    .i_in (I_in),
    .q_in (Q_in),
    .acc  (acc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      ch       <= '0;
      cnt      <= '0;
      base_q   <= '0;
      step_q   <= '0;
      best_phi <= '0;
      phi_inc  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      locked   <= 1'b0;
      best_ch  <= '0;
      best_mag <= '0;
    end else begin
      done <= 1'b0;
      // Abort overrides every scan state; partial best_* results are kept
      if (abort && state != ST_IDLE) begin
        state   <= ST_IDLE;
        phi_inc <= base_q;
        busy    <= 1'b0;
        locked  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (abort) begin
              locked <= 1'b0;
            end else if (start) begin
              base_q   <= base_phi;
              step_q   <= step_phi;
              ch       <= '0;
              phi_inc  <= base_phi;
              busy     <= 1'b1;
              locked   <= 1'b0;
              best_ch  <= '0;
              best_mag <= '0;
              cnt      <= '0;
              state    <= ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            if (cnt == SETTLE_LAST) begin
              cnt   <= '0;
              state <= ST_MEAS;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          ST_MEAS: begin
            if (cnt == MEAS_LAST) begin
              cnt   <= '0;
              state <= ST_CMP;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          ST_CMP: begin
            // Strict compare keeps the lower channel on a tie
            if (ch == '0 || acc > best_mag) begin
              best_mag <= acc;
              best_ch  <= ch;
              best_phi <= phi_inc;
            end
            if (ch == LAST_CH) begin
              state <= ST_LOCK;
            end else begin
              ch      <= ch + CH_W'(1);
              phi_inc <= phi_inc + step_q;
              state   <= ST_SETTLE;
            end
          end
          ST_LOCK: begin
            phi_inc <= best_phi;
            locked  <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/fm_scan_ctrl.md
FM_SCAN_CTRL -- requirements
Module: fm_scan_ctrl

Interface
REQ-001 SHALL have parameter N_CH, default 8: number of channels scanned (2..256).
REQ-002 SHALL have parameter SETTLE_CYC, default 64: cycles waited after each retune, before measuring (>=1).
REQ-003 SHALL have parameter MEAS_LOG2, default 8: log2 of the measurement window in cycles (1..14).
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge; one clock, reset asynchronous active-high.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: scan request, sampled on the clock edge.
REQ-007 SHALL have port abort, input, 1: cancels a scan in progress.
REQ-008 SHALL have port base_phi, input, 32: phase increment of channel 0.
REQ-009 SHALL have port step_phi, input, 32: phase-increment spacing between channels.
REQ-010 SHALL have port I_in, input, signed 16: filtered baseband I from the demodulator, valid every cycle.
REQ-011 SHALL have port Q_in, input, signed 16: filtered baseband Q, valid every cycle.
REQ-012 SHALL have port phi_inc, output, 32: registered NCO phase increment.
REQ-013 SHALL have port busy, output, 1: high while a scan is in progress.
REQ-014 SHALL have port done, output, 1: one-cycle pulse at scan completion.
REQ-015 SHALL have port locked, output, 1: phi_inc holds the best channel.
REQ-016 SHALL have port best_ch, output, $clog2(N_CH): index of the strongest channel.
REQ-017 SHALL have port best_mag, output, 32: window accumulation of the strongest channel.

Function
REQ-018 SHALL implement the states IDLE, SETTLE, MEAS, CMP and LOCK.
REQ-019 IDLE, with start=1 and abort=0, SHALL: set ch=0, phi_inc<=base_phi, busy<=1, locked<=0, clear best_ch/best_mag, clear the settle counter, go to SETTLE.
REQ-020 SETTLE SHALL last exactly SETTLE_CYC cycles, then go to MEAS with the accumulator cleared.
REQ-021 MEAS SHALL accumulate |I_in|+|Q_in| on each of 2^MEAS_LOG2 consecutive cycles, then go to CMP.
REQ-022 The absolute value SHALL be 17-bit unsigned, with |-32768| = 32768; the per-sample sum SHALL be 18 bits.
REQ-023 The accumulator SHALL be 32-bit unsigned and SHALL never overflow within the parameter ranges.
REQ-024 CMP (one cycle) SHALL set best_mag<=acc, best_ch<=ch and best_phi<=phi_inc when ch==0 or acc>best_mag; on a tie the lower channel SHALL be kept.
REQ-025 CMP, when ch<N_CH-1, SHALL set ch<=ch+1, phi_inc<=phi_inc+step_phi (mod 2^32, wrap permitted) and go to SETTLE.
REQ-026 CMP, when ch==N_CH-1, SHALL go to LOCK.
REQ-027 LOCK (one cycle) SHALL set phi_inc<=best_phi, locked<=1, busy<=0 and done=1, then go to IDLE.
REQ-028 phi_inc and locked SHALL hold in IDLE until the next start or abort.
REQ-029 With start accepted at edge k, busy SHALL be high from k+1, and done SHALL be high on exactly one cycle, N_CH*(SETTLE_CYC+2^MEAS_LOG2+1)+1 cycles after busy rises.
REQ-030 base_phi and step_phi SHALL be captured at start; later changes SHALL not affect the scan in progress.
REQ-031 start while busy SHALL be ignored.
REQ-032 abort in any non-IDLE state SHALL go to IDLE next cycle with phi_inc<=base_phi (captured), busy<=0, locked<=0, no done pulse; best_ch/best_mag SHALL hold partial results.
REQ-033 When start and abort are high together, abort SHALL win and no scan SHALL start.
REQ-034 abort in IDLE SHALL clear locked and leave phi_inc unchanged.

Reset
REQ-035 rst=1 SHALL asynchronously force state=IDLE and phi_inc, best_ch, best_mag, acc, counters, busy, done, locked all to 0.
REQ-036 Reset mid-scan SHALL discard the scan; after release, the block SHALL wait for a new start.

Structure
REQ-037 Shared package fm_pkg SHALL hold: scan state enum typedef; PHI_W=32; default N_CH/SETTLE_CYC/MEAS_LOG2 constants.
REQ-038 Sub-module iq_mag_acc (abs, sum, clear/enable accumulate, 32-bit result) SHALL be instantiated once.
REQ-039 All outputs SHALL be registered.

Verification (N_CH=4, SETTLE_CYC=4, MEAS_LOG2=3 unless noted)
REQ-040 Scan, constant I/Q per channel: base_phi=0x1000_0000, step_phi=0x0100_0000, I/Q per ch (100,0), (300,-200), (50,50), (0,-400); start pulse -> busy asserts next cycle, done after 4*13+1=53 cycles, best_ch=1, best_mag=4000, phi_inc=0x1100_0000, locked=1.
REQ-041 Tie and wrap: base_phi=0xFF00_0000, step_phi=0x0080_0000, equal amplitude on ch0 and ch2 -> best_ch=0; ch2 phi_inc observed during scan =0xFF00_0000+0x0100_0000 = 0x0000_0000.
REQ-042 Saturated magnitude: I=Q=-32768 on every channel, MEAS_LOG2=14 -> best_mag=2^30, no overflow, best_ch=0.
REQ-043 Abort: abort during ch2 MEAS -> next cycle IDLE, busy=0, done never pulses, locked=0, phi_inc=base_phi; start with abort in the same cycle -> busy stays 0.
REQ-044 Reset: rst asserted mid-SETTLE, asynchronously between clock edges -> all outputs 0 immediately; start with rst=1 ignored; a full scan after release matches REQ-040.
REQ-045 Restart: start pulsed while busy -> ignored, done count unchanged; second start after done -> new scan, locked drops to 0 on the cycle after start.
